// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, single-outstanding memory fetch, DEPTH-entry instruction FIFO, jump redirect/flush.
// Optional FETCH_JMP_CNT_EN adds a saturating 16-bit redirect counter output jmp_count.
module instruction_fetch #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_valid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instruction,
    input  logic               instr_ready,
    input  logic               load_pc,
    input  logic [ADDR_W-1:0]  load_pc_val
`ifdef FETCH_JMP_CNT_EN
    ,
    output logic [15:0]        jmp_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [INSTR_W-1:0] fifo [DEPTH];
    logic [INSTR_W-1:0] head_n;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_n;
    logic pop, push, redirect;
    always_comb begin
        pop      = instr_valid & instr_ready;
        redirect = pop & load_pc;
        push     = (state == WAIT) & mem_valid & ~redirect;
        count_n  = redirect ? '0 : count + CW'(push) - CW'(pop);
        pc_n     = redirect ? load_pc_val : push ? pc + 1'b1 : pc;
        // a word landing in an empty (after pop) FIFO becomes the head directly
        head_n   = (push && count == CW'(pop)) ? mem_rdata : fifo[rd_ptr + PW'(pop)];
        state_n  = state == IDLE ? (count_n < CW'(DEPTH) ? REQ : IDLE)
                 : state == REQ  ? (redirect ? DRAIN : WAIT)
                 : mem_valid     ? ((state == DRAIN || count_n < CW'(DEPTH)) ? REQ : IDLE)
                 : redirect      ? DRAIN : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instruction <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            count       <= count_n;
            rd_ptr      <= redirect ? '0 : pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr      <= redirect ? '0 : push ? wr_ptr + 1'b1 : wr_ptr;
            mem_req     <= state_n == REQ;
            mem_addr    <= pc_n;
            instr_valid <= count_n != '0;
            instruction <= head_n;
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= mem_rdata;
    end
`ifdef FETCH_JMP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) jmp_count <= '0;
        else if (redirect && jmp_count != 16'hFFFF) jmp_count <= jmp_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random memory latency/decoder stimulus checked against an instruction-stream model.
module tb_instruction_fetch;
    localparam int AW = 12, IW = 16, DEPTH = 2;
    logic clk = 0, rst_n = 0, mem_valid = 0, instr_ready = 0, load_pc = 0;
    logic mem_req, instr_valid;
    logic [AW-1:0] mem_addr, load_pc_val = '0;
    logic [IW-1:0] mem_rdata = '0, instruction;
`ifdef FETCH_JMP_CNT_EN
    logic [15:0] jmp_count;
`endif
    always #5 clk = ~clk;
    instruction_fetch #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instruction(instruction), .instr_ready(instr_ready), .load_pc(load_pc),
        .load_pc_val(load_pc_val)
`ifdef FETCH_JMP_CNT_EN
        , .jmp_count(jmp_count)
`endif
    );
    int checks = 0, errors = 0;
    logic [IW-1:0] mem [1 << AW];
    logic [AW-1:0] exp_pc = '0, pend_addr;
    int redirects = 0, pops = 0, reqs = 0, cyc = 0, pend_due = 0, max_lat = 1;
    bit pend = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic reset_checks(string p);
        check({p, "_mem_req"}, 32'(mem_req), 0);
        check({p, "_mem_addr"}, 32'(mem_addr), 0);
        check({p, "_instr_valid"}, 32'(instr_valid), 0);
        check({p, "_instruction"}, 32'(instruction), 0);
`ifdef FETCH_JMP_CNT_EN
        check({p, "_jmp_count"}, 32'(jmp_count), 0);
`endif
    endtask
    // One cycle: sample DUT at negedge, answer memory, act as the decoder, check popped words.
    task automatic step(int ready_pct, int jmp_pct);
        int r;
        @(negedge clk);
        cyc++;
        if (mem_req) begin
            check("one_outstanding", 32'(pend), 0);
            pend = 1;
            pend_addr = mem_addr;
            pend_due = cyc + int'($urandom_range(max_lat, 1));
            reqs++;
        end
        mem_valid = 0;
        if (pend && pend_due == cyc) begin
            mem_valid = 1;
            mem_rdata = mem[pend_addr];
            pend = 0;
        end
        instr_ready = int'($urandom_range(99)) < ready_pct;
        load_pc = int'($urandom_range(99)) < jmp_pct;
        r = int'($urandom_range(3));
        load_pc_val = r == 0 ? 12'hFFF : r == 1 ? 12'hFFE : AW'($urandom);
        if (instr_valid && instr_ready) begin
            check("instr", 32'(instruction), 32'(mem[exp_pc]));
            pops++;
            if (load_pc) begin
                exp_pc = load_pc_val;
                redirects++;
            end else exp_pc = exp_pc + 1'b1;
        end
    endtask
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
        mem[0] = 16'h1123;
        mem[12'hFFF] = 16'h1000;
        repeat (2) @(negedge clk);
        #1 reset_checks("rst");
        @(negedge clk);
        rst_n = 1;
        step(0, 0);
        check("t1_req", 32'(mem_req), 1);
        check("t1_addr", 32'(mem_addr), 0);
        step(0, 0);
        check("t1_req_wait", 32'(mem_req), 0);
        check("t1_valid_early", 32'(instr_valid), 0);
        step(0, 0);
        check("t1_valid", 32'(instr_valid), 1);
        check("t1_instr", 32'(instruction), 32'h1123);
        max_lat = 3;
        repeat (40) step(0, 0);
        check("t2_reqs", 32'(reqs), DEPTH);
        check("t2_held", 32'(instr_valid), 1);
        check("t2_req_stop", 32'(mem_req), 0);
        repeat (1500) step(70, 0);
        repeat (3000) step(70, 15);
        check("progress", 32'(pops > 800), 1);
        for (int i = 0; i < 50 && !pend; i++) step(70, 0);
        check("t6_pending", 32'(pend), 1);
        #2 rst_n = 0;
        #1 reset_checks("t6_rst");
        mem_valid = 1;
        mem_rdata = 16'hDEAD;
        repeat (2) @(negedge clk);
        reset_checks("t6_hold");
        rst_n = 1;
        pend = 0;
        exp_pc = '0;
        redirects = 0;
        step(0, 0);
        check("t6_req", 32'(mem_req), 1);
        check("t6_addr", 32'(mem_addr), 0);
        repeat (2000) step(60, 25);
`ifdef FETCH_JMP_CNT_EN
        check("jmp_count", 32'(jmp_count), 32'(redirects));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
